// File: rtl/usb_ctrl_out_pio.sv
// Avalon-MM output PIO for USB controller sideband lines.
// Atomic set/clear plus hardware-timed pulses that invert masked lines.
module usb_ctrl_out_pio #(
  parameter int                   WIDTH       = 4,
  parameter logic [WIDTH-1:0]     RESET_VALUE = 4'hF,
  parameter int                   CNT_WIDTH   = 16,
  parameter logic [CNT_WIDTH-1:0] DEFAULT_LEN = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {
    IDLE,
    PULSE
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [WIDTH-1:0]     data_reg;
  logic [WIDTH-1:0]     data_d;
  logic [WIDTH-1:0]     mask_reg;
  logic [WIDTH-1:0]     mask_d;
  logic [WIDTH-1:0]     wmask;
  logic [CNT_WIDTH-1:0] pulse_len;
  logic [CNT_WIDTH-1:0] len_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [31:0]          rd_d;
  logic                 wr;
  logic                 wr_data;
  logic                 wr_len;
  logic                 wr_pulse;
  logic                 wr_set;
  logic                 wr_clr;
  logic                 busy;
  logic                 unused_wd;

  assign wr       = chipselect & ~write_n;
  assign wr_data  = wr && (address == 3'd0);
  assign wr_len   = wr && (address == 3'd1);
  assign wr_pulse = wr && (address == 3'd2);
  assign wr_set   = wr && (address == 3'd4);
  assign wr_clr   = wr && (address == 3'd5);
  assign wmask    = writedata[WIDTH-1:0];
  assign busy     = (state == PULSE);
  assign unused_wd = ^writedata;

  assign out_port = data_reg ^ (busy ? mask_reg : '0);

  always_comb begin
    data_d = data_reg;
    len_d  = pulse_len;
    unique case (1'b1)
      wr_data: data_d = wmask;
      wr_len:  len_d  = writedata[CNT_WIDTH-1:0];
      wr_set:  data_d = data_reg | wmask;
      wr_clr:  data_d = data_reg & ~wmask;
      default: ;
    endcase
  end

  // Retrigger is ignored while a pulse runs; length is latched at start.
  always_comb begin
    state_d = state;
    mask_d  = mask_reg;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (wr_pulse && (pulse_len != '0) && (wmask != '0)) begin
          state_d = PULSE;
          mask_d  = wmask;
          cnt_d   = pulse_len;
        end
      end
      PULSE: begin
        cnt_d = cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) begin
          state_d = IDLE;
          mask_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d = '0;
    case (address)
      3'd0:    rd_d = 32'(data_reg);
      3'd1:    rd_d = 32'(pulse_len);
      3'd2:    rd_d = 32'({mask_reg, 7'd0, busy});
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data_reg  <= RESET_VALUE;
      pulse_len <= DEFAULT_LEN;
      mask_reg  <= '0;
      cnt       <= '0;
      readdata  <= '0;
    end else begin
      state     <= state_d;
      data_reg  <= data_d;
      pulse_len <= len_d;
      mask_reg  <= mask_d;
      cnt       <= cnt_d;
      readdata  <= rd_d;
    end
  end

endmodule

// File: tb/tb_usb_ctrl_out_pio.sv
// Bench for usb_ctrl_out_pio: directed register checks plus
// randomized bus traffic against a cycle-indexed pulse model.
module tb_usb_ctrl_out_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int total = 0;
  int bad   = 0;

  usb_ctrl_out_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pulse started at edge k stays active after edges k..k+len-1.
  int          e     = 0;
  int          p_end = -1;
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  logic [15:0] m_len;
  logic [31:0] exp_rd;
  logic [3:0]  exp_out;
  bit          mvalid = 0;

  always @(posedge clk) begin
    bit         bb;
    logic [3:0] mk;
    if (reset) begin
      m_data = 4'hF;
      m_len  = 16'd1000;
      m_mask = 4'h0;
      p_end  = e;
      exp_rd = 32'd0;
      mvalid = 1;
    end else begin
      bb = (e - 1) < p_end;
      mk = bb ? m_mask : 4'h0;
      case (address)
        3'd0:    exp_rd = {28'd0, m_data};
        3'd1:    exp_rd = {16'd0, m_len};
        3'd2:    exp_rd = {20'd0, mk, 7'd0, bb};
        default: exp_rd = 32'd0;
      endcase
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[3:0];
          3'd1: m_len = writedata[15:0];
          3'd2: begin
            if (!bb && m_len != 0 && writedata[3:0] != 0) begin
              m_mask = writedata[3:0];
              p_end  = e + int'(m_len);
            end
          end
          3'd4: m_data = m_data | writedata[3:0];
          3'd5: m_data = m_data & ~writedata[3:0];
          default: ;
        endcase
      end
    end
    exp_out = m_data ^ ((e < p_end) ? m_mask : 4'h0);
    e++;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("model out_port", {28'd0, out_port}, {28'd0, exp_out});
      check("model readdata", readdata, exp_rd);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    address    = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset out", {28'd0, out_port}, 32'hF);
    rd(3'd1);
    check("reset len", readdata, 32'd1000);
    rd(3'd2);
    check("reset busy", readdata, 32'd0);

    wr(3'd0, 32'h5);
    check("data 5", {28'd0, out_port}, 32'h5);
    wr(3'd4, 32'h2);
    check("outset", {28'd0, out_port}, 32'h7);
    wr(3'd5, 32'h4);
    check("outclear", {28'd0, out_port}, 32'h3);
    rd(3'd0);
    check("read data", readdata, 32'h3);

    wr(3'd0, 32'hF);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'h1);
    check("pulse c1", {28'd0, out_port}, 32'hE);
    rd(3'd2);
    check("pulse busy", readdata, 32'h101);
    check("pulse c2", {28'd0, out_port}, 32'hE);
    idle(1);
    check("pulse c3", {28'd0, out_port}, 32'hE);
    idle(1);
    check("pulse end", {28'd0, out_port}, 32'hF);
    rd(3'd2);
    check("pulse idle", readdata, 32'd0);

    wr(3'd1, 32'd1000);
    wr(3'd2, 32'h1);
    check("long start", {28'd0, out_port}, 32'hE);
    wr(3'd2, 32'h2);
    check("no retrig", {28'd0, out_port}, 32'hE);
    wr(3'd5, 32'h8);
    check("clr in pulse", {28'd0, out_port}, 32'h6);
    idle(997);
    check("long last", {28'd0, out_port}, 32'h6);
    idle(1);
    check("long end", {28'd0, out_port}, 32'h7);

    wr(3'd1, 32'd0);
    wr(3'd2, 32'h1);
    check("zero len", {28'd0, out_port}, 32'h7);
    rd(3'd2);
    check("zero busy", readdata, 32'd0);

    wr(3'd1, 32'd20);
    wr(3'd2, 32'h1);
    check("pre reset", {28'd0, out_port}, 32'h6);
    reset = 1'b1;
    idle(1);
    check("mid reset", {28'd0, out_port}, 32'hF);
    reset = 1'b0;
    rd(3'd2);
    check("rst busy", readdata, 32'd0);
    rd(3'd1);
    check("rst len", readdata, 32'd1000);

    for (int i = 0; i < 3000; i++) begin
      r          = $urandom_range(0, 199);
      reset      = (r == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 1) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if (address == 3'd1)
        writedata = $urandom_range(0, 12);
      @(posedge clk);
      #1;
    end
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
